// File: rtl/matrix_key_digit_entry.sv
// Decimal digit-entry stage: edge-detects debounced key levels, edits an NUM-digit
// BCD buffer, drives registered 7-segment bitmaps and latches the value on ENTER.
module matrix_key_digit_entry #(
  parameter int unsigned NUM = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [15:0]                key_out,
  output logic [NUM-1:0][7:0]        led_in,
  output logic [4*NUM-1:0]           value,
  output logic                       value_valid,
  output logic [$clog2(NUM+1)-1:0]   digit_count
);

  localparam int unsigned CW = $clog2(NUM+1);

  typedef enum logic [1:0] {EMPTY, EDIT, COMMITTED} state_t;

  state_t               state_q, state_d;
  logic [15:0]          key_prev;
  logic [15:0]          new_press;
  logic [NUM-1:0][3:0]  dig_q, dig_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM-1:0][7:0]  led_d;
  logic                 press;
  logic [3:0]           key;
  logic                 commit;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  assign new_press   = key_out & ~key_prev;
  assign digit_count = cnt_q;

  // Lowest-index new press wins; the rest are dropped for good since key_prev advances anyway.
  always_comb begin
    press = 1'b0;
    key   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (new_press[i] && !press) begin
        press = 1'b1;
        key   = 4'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (press) begin
      unique case (state_q)
        EMPTY: begin
          if (key < 4'd10) begin
            dig_d    = '0;
            dig_d[0] = key;
            cnt_d    = CW'(1);
            state_d  = EDIT;
          end
        end
        EDIT: begin
          if (key < 4'd10) begin
            if (32'(cnt_q) < NUM) begin
              for (int unsigned i = 1; i < NUM; i++) dig_d[i] = dig_q[i-1];
              dig_d[0] = key;
              cnt_d    = cnt_q + CW'(1);
            end
          end else if (key == 4'd10) begin
            if (cnt_q > CW'(1)) begin
              for (int unsigned i = 0; i + 1 < NUM; i++) dig_d[i] = dig_q[i+1];
              dig_d[NUM-1] = '0;
              cnt_d        = cnt_q - CW'(1);
            end else begin
              dig_d   = '0;
              cnt_d   = '0;
              state_d = EMPTY;
            end
          end else if (key == 4'd11) begin
            dig_d   = '0;
            cnt_d   = '0;
            state_d = EMPTY;
          end else if (key == 4'd12) begin
            commit  = 1'b1;
            state_d = COMMITTED;
          end
        end
        COMMITTED: begin
          if (key < 4'd10) begin
            dig_d    = '0;
            dig_d[0] = key;
            cnt_d    = CW'(1);
            state_d  = EDIT;
          end else if (key == 4'd11) begin
            dig_d   = '0;
            cnt_d   = '0;
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Display is built from next-state values so it lands on the same edge as the action.
  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (i < 32'(cnt_d))
        led_d[i] = seg7(dig_d[i]);
      else if (i == 32'(cnt_d) && state_d != COMMITTED)
        led_d[i] = 8'h80;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= EMPTY;
      key_prev    <= '0;
      dig_q       <= '0;
      cnt_q       <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      led_in      <= '0;
      led_in[0]   <= 8'h80;
    end else begin
      state_q     <= state_d;
      key_prev    <= key_out;
      dig_q       <= dig_d;
      cnt_q       <= cnt_d;
      value_valid <= commit;
      led_in      <= led_d;
      if (commit) value <= dig_q;
    end
  end

endmodule

// File: tb/tb_matrix_key_digit_entry.sv
// Self-checking bench for matrix_key_digit_entry (NUM=8): directed scenarios plus
// randomized key traffic checked against a digit-queue reference model.
module tb_matrix_key_digit_entry;

  logic            clk = 1'b0;
  logic            rstn;
  logic [15:0]     key_out;
  logic [7:0][7:0] led_in;
  logic [31:0]     value;
  logic            value_valid;
  logic [3:0]      digit_count;

  int npass  = 0;
  int ntotal = 0;

  matrix_key_digit_entry #(.NUM(8)) dut (
    .clk(clk), .rstn(rstn), .key_out(key_out), .led_in(led_in),
    .value(value), .value_valid(value_valid), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  // Reference model: q[0] is the newest digit; committed means the entry is frozen.
  logic [7:0]  seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  int          q[$];
  bit          mcom;
  logic [31:0] mval;
  bit          mvalid;
  logic [15:0] mprev;

  task automatic model_reset();
    q.delete(); mcom = 0; mval = '0; mvalid = 0; mprev = '0;
  endtask

  task automatic model_step(input logic [15:0] k);
    logic [15:0] rising;
    int          key;
    rising = k & ~mprev;
    mprev  = k;
    mvalid = 0;
    key    = -1;
    for (int i = 15; i >= 0; i--) if (rising[i]) key = i;
    if (key >= 0 && key <= 9) begin
      if (mcom) begin q.delete(); q.push_front(key); mcom = 0; end
      else if (q.size() < 8) q.push_front(key);
    end else if (key == 10) begin
      if (!mcom && q.size() > 0) void'(q.pop_front());
    end else if (key == 11) begin
      q.delete(); mcom = 0;
    end else if (key == 12) begin
      if (!mcom && q.size() > 0) begin
        mval = '0;
        foreach (q[i]) mval[4*i +: 4] = q[i][3:0];
        mvalid = 1; mcom = 1;
      end
    end
  endtask

  function automatic logic [63:0] exp_led();
    logic [63:0] r = '0;
    foreach (q[i]) r[8*i +: 8] = seg_tab[q[i]];
    if (!mcom && q.size() < 8) r[8*q.size() +: 8] = 8'h80;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(key_out);
    #1;
  endtask

  task automatic press(input int k);
    @(negedge clk) key_out[k] = 1'b1;
    repeat (5) cycle();
    @(negedge clk) key_out[k] = 1'b0;
    repeat (5) cycle();
  endtask

  task automatic test_reset();
    rstn = 1'b0; key_out = '0; model_reset();
    #12;
    ntotal++; if (led_in !== 64'h80) $display("FAIL reset_led: got %h want %h", led_in, 64'h80); else npass++;
    ntotal++; if (digit_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", digit_count); else npass++;
    ntotal++; if (value_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", value_valid); else npass++;
    ntotal++; if (value !== 32'h0) $display("FAIL reset_value: got %h want 0", value); else npass++;
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic test_entry();
    press(1); press(2); press(3);
    ntotal++; if (led_in[2:0] !== 24'h065B4F) $display("FAIL entry_digits: got %h want 065b4f", led_in[2:0]); else npass++;
    ntotal++; if (led_in[3] !== 8'h80) $display("FAIL entry_cursor: got %h want 80", led_in[3]); else npass++;
    ntotal++; if (digit_count !== 4'd3) $display("FAIL entry_count: got %0d want 3", digit_count); else npass++;
    @(negedge clk) key_out[12] = 1'b1;
    cycle();
    ntotal++; if (value_valid !== 1'b1) $display("FAIL enter_valid: got %b want 1", value_valid); else npass++;
    ntotal++; if (value !== 32'h0000_0123) $display("FAIL enter_value: got %h want 00000123", value); else npass++;
    ntotal++; if (led_in[3] !== 8'h00) $display("FAIL enter_nocursor: got %h want 00", led_in[3]); else npass++;
    cycle();
    ntotal++; if (value_valid !== 1'b0) $display("FAIL enter_pulse: got %b want 0", value_valid); else npass++;
    @(negedge clk) key_out[12] = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_overflow();
    press(11);
    for (int d = 1; d <= 9; d++) press(d);
    ntotal++; if (digit_count !== 4'd8) $display("FAIL full_count: got %0d want 8", digit_count); else npass++;
    ntotal++; if (led_in[0] !== 8'h7F) $display("FAIL full_led0: got %h want 7f", led_in[0]); else npass++;
    ntotal++; if (led_in[7] !== 8'h06) $display("FAIL full_led7: got %h want 06", led_in[7]); else npass++;
    press(10);
    ntotal++; if (digit_count !== 4'd7) $display("FAIL bksp_count: got %0d want 7", digit_count); else npass++;
    ntotal++; if (led_in[0] !== 8'h07) $display("FAIL bksp_led0: got %h want 07", led_in[0]); else npass++;
    ntotal++; if (led_in[7] !== 8'h80) $display("FAIL bksp_cursor: got %h want 80", led_in[7]); else npass++;
  endtask

  task automatic test_simultaneous();
    press(11);
    @(negedge clk) key_out = 16'h0028;
    repeat (5) cycle();
    ntotal++; if (digit_count !== 4'd1) $display("FAIL simul_count: got %0d want 1", digit_count); else npass++;
    ntotal++; if (led_in[1:0] !== 16'h804F) $display("FAIL simul_led: got %h want 804f", led_in[1:0]); else npass++;
    @(negedge clk) key_out = 16'h0020;
    repeat (4) cycle();
    ntotal++; if (digit_count !== 4'd1) $display("FAIL held_count: got %0d want 1", digit_count); else npass++;
    @(negedge clk) key_out = '0;
    repeat (3) cycle();
  endtask

  task automatic test_recommit();
    press(11); press(4); press(2); press(12);
    ntotal++; if (value !== 32'h42) $display("FAIL commit_value: got %h want 42", value); else npass++;
    press(7);
    ntotal++; if (digit_count !== 4'd1) $display("FAIL recommit_count: got %0d want 1", digit_count); else npass++;
    ntotal++; if (led_in[1:0] !== 16'h8007) $display("FAIL recommit_led: got %h want 8007", led_in[1:0]); else npass++;
    ntotal++; if (value !== 32'h42) $display("FAIL recommit_value: got %h want 42", value); else npass++;
    press(11);
    ntotal++; if (led_in !== 64'h80) $display("FAIL clear_led: got %h want 80", led_in); else npass++;
    ntotal++; if (value !== 32'h42) $display("FAIL clear_value: got %h want 42", value); else npass++;
  endtask

  task automatic test_empty_cmds();
    @(negedge clk) key_out[12] = 1'b1;
    cycle();
    ntotal++; if (value_valid !== 1'b0) $display("FAIL empty_enter_valid: got %b want 0", value_valid); else npass++;
    @(negedge clk) key_out = 16'h0400;
    cycle();
    ntotal++; if (led_in !== 64'h80) $display("FAIL empty_bksp_led: got %h want 80", led_in); else npass++;
    ntotal++; if (digit_count !== 4'd0) $display("FAIL empty_bksp_count: got %0d want 0", digit_count); else npass++;
    @(negedge clk) key_out = '0;
    repeat (3) cycle();
  endtask

  task automatic test_reset_mid();
    press(5);
    @(negedge clk) key_out[12] = 1'b1;
    cycle();
    ntotal++; if (value_valid !== 1'b1) $display("FAIL mid_pulse: got %b want 1", value_valid); else npass++;
    #2 rstn = 1'b0;
    #1;
    ntotal++; if (value_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", value_valid); else npass++;
    ntotal++; if (led_in !== 64'h80) $display("FAIL mid_led: got %h want 80", led_in); else npass++;
    ntotal++; if (value !== 32'h0) $display("FAIL mid_value: got %h want 0", value); else npass++;
    ntotal++; if (digit_count !== 4'd0) $display("FAIL mid_count: got %0d want 0", digit_count); else npass++;
    model_reset();
    key_out = 16'h0040;
    @(negedge clk) rstn = 1'b1;
    cycle();
    ntotal++; if (led_in[1:0] !== 16'h807D) $display("FAIL heldrst_led: got %h want 807d", led_in[1:0]); else npass++;
    ntotal++; if (digit_count !== 4'd1) $display("FAIL heldrst_count: got %0d want 1", digit_count); else npass++;
    @(negedge clk) key_out = '0;
    repeat (3) cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int unsigned r, k;
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 15);
      @(negedge clk);
      if (r < 3) key_out = '0;
      else if (r < 8) key_out = 16'h1 << k;
      else key_out = key_out | (16'h1 << k);
      cycle();
      ntotal++; if (led_in !== exp_led()) $display("FAIL rnd_led[%0d]: got %h want %h", n, led_in, exp_led()); else npass++;
      ntotal++; if (32'(digit_count) !== q.size()) $display("FAIL rnd_count[%0d]: got %0d want %0d", n, digit_count, q.size()); else npass++;
      ntotal++; if (value !== mval) $display("FAIL rnd_value[%0d]: got %h want %h", n, value, mval); else npass++;
      ntotal++; if (value_valid !== mvalid) $display("FAIL rnd_valid[%0d]: got %b want %b", n, value_valid, mvalid); else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_overflow();
    test_simultaneous();
    test_recommit();
    test_empty_cmds();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
